// File: rtl/i2c_cmd_sequencer.sv
// rtl/i2c_cmd_sequencer.sv - command/response queue front end that drives one I2C master transaction at a time
// Each queued command gets exactly one response, either carrying read data or flagging a handshake timeout.

module i2c_cmd_sequencer_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             empty,
    output logic             full
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_COUNT = DEPTH[AW:0];

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    // Overflowing pushes and underflowing pops are silently dropped here.
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign empty   = (count == '0);
    assign full    = (count == FULL_COUNT);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end
endmodule

module i2c_cmd_sequencer #(
    parameter int CMD_DEPTH = 4,
    parameter int RSP_DEPTH = 4,
    parameter int TIMEOUT   = 2048
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [6:0] cmd_addr,
    input  logic       cmd_rw,
    input  logic [7:0] cmd_data,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic [7:0] rsp_data,
    output logic       rsp_rw,
    output logic       rsp_err,
    output logic [6:0] m_addr,
    output logic [7:0] m_data_in,
    output logic       m_rw,
    output logic       m_enable,
    input  logic       m_ready,
    input  logic [7:0] m_data_out,
    output logic       busy,
    output logic [7:0] err_count
);
    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_BUSY,
        S_RESP
    } state_t;

    localparam logic [15:0] T_LAST = 16'(TIMEOUT - 1);

    state_t      state;
    state_t      state_next;
    logic        cmd_empty;
    logic        cmd_full;
    logic        rsp_empty;
    logic        rsp_full;
    logic [15:0] cmd_head;
    logic [9:0]  rsp_head;
    logic [9:0]  rsp_word;
    logic        issue;
    logic        rsp_push;
    logic        timeout;
    logic [15:0] tmo_cnt;
    logic [7:0]  rdata_q;

    i2c_cmd_sequencer_fifo #(
        .DEPTH (CMD_DEPTH),
        .WIDTH (16)
    ) u_cmd_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (cmd_valid),
        .push_data ({cmd_addr, cmd_rw, cmd_data}),
        .pop       (issue),
        .head      (cmd_head),
        .empty     (cmd_empty),
        .full      (cmd_full)
    );

    i2c_cmd_sequencer_fifo #(
        .DEPTH (RSP_DEPTH),
        .WIDTH (10)
    ) u_rsp_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (rsp_push),
        .push_data (rsp_word),
        .pop       (rsp_ready),
        .head      (rsp_head),
        .empty     (rsp_empty),
        .full      (rsp_full)
    );

    // Response fields are forced to zero when nothing is queued so reset values hold.
    assign cmd_ready = !cmd_full;
    assign rsp_valid = !rsp_empty;
    assign rsp_data  = rsp_valid ? rsp_head[9:2] : 8'h00;
    assign rsp_rw    = rsp_valid & rsp_head[1];
    assign rsp_err   = rsp_valid & rsp_head[0];
    assign busy      = (state != S_IDLE) || !cmd_empty;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Issue needs a free response slot, so the single outstanding response can always be pushed.
    always_comb begin
        state_next = state;
        issue      = 1'b0;
        timeout    = 1'b0;
        rsp_push   = 1'b0;
        rsp_word   = '0;
        case (state)
            S_IDLE: begin
                if (!cmd_empty && !rsp_full && m_ready) begin
                    issue      = 1'b1;
                    state_next = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (!m_ready) begin
                    state_next = S_BUSY;
                end else if (tmo_cnt == T_LAST) begin
                    timeout = 1'b1;
                end
            end
            S_BUSY: begin
                if (m_ready) begin
                    state_next = S_RESP;
                end else if (tmo_cnt == T_LAST) begin
                    timeout = 1'b1;
                end
            end
            S_RESP: begin
                rsp_push   = 1'b1;
                rsp_word   = {rdata_q, m_rw, 1'b0};
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
        if (timeout) begin
            rsp_push   = 1'b1;
            rsp_word   = {8'h00, m_rw, 1'b1};
            state_next = S_IDLE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_addr    <= '0;
            m_rw      <= 1'b0;
            m_data_in <= '0;
            m_enable  <= 1'b0;
            tmo_cnt   <= '0;
            rdata_q   <= '0;
            err_count <= '0;
        end else begin
            // Enable is held only while waiting for the master to take the command.
            m_enable <= (state_next == S_ISSUE);
            if (issue) begin
                m_addr    <= cmd_head[15:9];
                m_rw      <= cmd_head[8];
                m_data_in <= cmd_head[7:0];
            end
            if (state_next != state) begin
                tmo_cnt <= '0;
            end else if (state == S_ISSUE || state == S_BUSY) begin
                tmo_cnt <= tmo_cnt + 16'd1;
            end
            if (state == S_BUSY && m_ready) begin
                rdata_q <= m_rw ? m_data_out : 8'h00;
            end
            if (timeout && err_count != 8'hFF) begin
                err_count <= err_count + 8'd1;
            end
        end
    end
endmodule

// File: tb/tb_i2c_cmd_sequencer.sv
// tb/tb_i2c_cmd_sequencer.sv - randomized bench with a transaction-level reference model and a behavioural I2C master
module tb_i2c_cmd_sequencer;
    localparam int CD = 4;
    localparam int RD = 4;
    localparam int TO = 40;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [6:0] cmd_addr = '0;
    logic       cmd_rw = 1'b0;
    logic [7:0] cmd_data = '0;
    logic       rsp_valid;
    logic       rsp_ready = 1'b0;
    logic [7:0] rsp_data;
    logic       rsp_rw;
    logic       rsp_err;
    logic [6:0] m_addr;
    logic [7:0] m_data_in;
    logic       m_rw;
    logic       m_enable;
    logic       m_ready = 1'b1;
    logic [7:0] m_data_out = '0;
    logic       busy;
    logic [7:0] err_count;

    always #5 clk = ~clk;

    i2c_cmd_sequencer #(
        .CMD_DEPTH (CD),
        .RSP_DEPTH (RD),
        .TIMEOUT   (TO)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_addr   (cmd_addr),
        .cmd_rw     (cmd_rw),
        .cmd_data   (cmd_data),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_data   (rsp_data),
        .rsp_rw     (rsp_rw),
        .rsp_err    (rsp_err),
        .m_addr     (m_addr),
        .m_data_in  (m_data_in),
        .m_rw       (m_rw),
        .m_enable   (m_enable),
        .m_ready    (m_ready),
        .m_data_out (m_data_out),
        .busy       (busy),
        .err_count  (err_count)
    );

    int n_checks = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: queued commands, queued responses, and one open transaction record.
    logic [15:0] mq[$];
    logic [9:0]  rq[$];
    bit          e_en = 0;
    logic [6:0]  e_addr = '0;
    logic        e_rw = 1'b0;
    logic [7:0]  e_din = '0;
    int          e_errs = 0;
    bit          txn_open = 0;
    bit          txn_started = 0;
    bit          resp_pending = 0;
    int          txn_age = 0;
    logic [9:0]  resp_word = '0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mq.delete();
            rq.delete();
            e_en = 0; e_addr = '0; e_rw = 1'b0; e_din = '0; e_errs = 0;
            txn_open = 0; txn_started = 0; resp_pending = 0; txn_age = 0;
        end else begin
            bit acc_cmd;
            bit pop_rsp;
            bit got_rsp;
            logic [9:0] w;
            acc_cmd = cmd_valid && (mq.size() < CD);
            pop_rsp = rsp_ready && (rq.size() > 0);
            got_rsp = 0;
            w = '0;
            if (resp_pending) begin
                got_rsp = 1; w = resp_word; resp_pending = 0; txn_open = 0;
            end else if (txn_open) begin
                if (!txn_started && !m_ready) begin
                    txn_started = 1; txn_age = 0; e_en = 0;
                end else if (txn_started && m_ready) begin
                    resp_word = {(e_rw ? m_data_out : 8'h00), e_rw, 1'b0};
                    resp_pending = 1;
                end else if (txn_age == TO - 1) begin
                    got_rsp = 1; w = {8'h00, e_rw, 1'b1}; e_en = 0; txn_open = 0;
                    if (e_errs < 255) e_errs++;
                end else begin
                    txn_age++;
                end
            end else if (mq.size() > 0 && rq.size() < RD && m_ready) begin
                {e_addr, e_rw, e_din} = mq.pop_front();
                e_en = 1; txn_open = 1; txn_started = 0; txn_age = 0;
            end
            if (pop_rsp) void'(rq.pop_front());
            if (got_rsp) rq.push_back(w);
            if (acc_cmd) mq.push_back({cmd_addr, cmd_rw, cmd_data});
        end
    end

    int en_cycles = 0;
    int pops = 0;

    always @(negedge clk) begin
        chk("cmd_ready", cmd_ready, mq.size() < CD);
        chk("rsp_valid", rsp_valid, rq.size() > 0);
        if (rq.size() > 0) begin
            chk("rsp_word", {rsp_data, rsp_rw, rsp_err}, rq[0]);
            if (rsp_ready && !rst) pops++;
        end
        chk("m_enable", m_enable, e_en);
        chk("m_cmd", {m_addr, m_rw, m_data_in}, {e_addr, e_rw, e_din});
        chk("busy", busy, txn_open || (mq.size() > 0));
        chk("err_count", err_count, e_errs);
        if (m_enable) en_cycles++;
    end

    // Behavioural master: drops ready after enable, holds it low, then returns data.
    bit         hold_off = 0;
    bit         dead_mode = 0;
    bit         rand_faults = 0;
    bit         use_fixed = 0;
    logic [7:0] fixed_data = '0;
    int         stretch = 0;
    int         ms = 0;
    int         dly = 0;
    int         hold = 0;
    bit         ign = 0;

    initial forever begin
        @(negedge clk);
        if (rst) begin
            ms = 0; ign = 0; m_ready = 1'b1;
        end else begin
            case (ms)
                0: begin
                    m_ready = !hold_off;
                    if (!m_enable) begin
                        ign = 0;
                    end else if (!ign) begin
                        if (dead_mode || (rand_faults && $urandom_range(0, 19) == 0)) begin
                            ign = 1;
                        end else begin
                            ms = 1; dly = $urandom_range(0, 2);
                        end
                    end
                end
                1: begin
                    if (dly == 0) begin
                        m_ready = 1'b0; ms = 2;
                        if (stretch > 0) hold = stretch;
                        else if (rand_faults && $urandom_range(0, 19) == 0) hold = TO + 5;
                        else hold = $urandom_range(1, 6);
                    end else begin
                        dly--;
                    end
                end
                default: begin
                    if (hold == 0) begin
                        m_ready = 1'b1;
                        m_data_out = use_fixed ? fixed_data : 8'($urandom);
                        ms = 0;
                    end else begin
                        hold--;
                        m_data_out = 8'($urandom);
                    end
                end
            endcase
        end
    end

    int rsp_mode = 0;

    initial forever begin
        @(posedge clk);
        #1;
        case (rsp_mode)
            0: rsp_ready = 1'b0;
            1: rsp_ready = 1'b1;
            default: rsp_ready = ($urandom_range(0, 2) != 0);
        endcase
    end

    task automatic push(input logic [6:0] a, input logic rw, input logic [7:0] d);
        bit ok = 0;
        cmd_addr = a; cmd_rw = rw; cmd_data = d; cmd_valid = 1'b1;
        for (int i = 0; i < 1000 && !ok; i++) begin
            @(negedge clk);
            if (cmd_ready) ok = 1;
        end
        chk("push_accept", ok, 1);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_rsp(input int lim);
        bit ok = 0;
        for (int i = 0; i < lim && !ok; i++) begin
            @(negedge clk);
            if (rsp_valid) ok = 1;
        end
        chk("rsp_wait", ok, 1);
    endtask

    task automatic drain(input int lim);
        bit ok = 0;
        rsp_mode = 1;
        for (int i = 0; i < lim && !ok; i++) begin
            @(negedge clk);
            if (!rsp_valid && !busy) ok = 1;
        end
        chk("drain", ok, 1);
        rsp_mode = 0;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_values();
        chk("rst_cmd_ready", cmd_ready, 1);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_data", rsp_data, 0);
        chk("rst_rsp_rw", rsp_rw, 0);
        chk("rst_rsp_err", rsp_err, 0);
        chk("rst_m_addr", m_addr, 0);
        chk("rst_m_data_in", m_data_in, 0);
        chk("rst_m_rw", m_rw, 0);
        chk("rst_m_enable", m_enable, 0);
        chk("rst_busy", busy, 0);
        chk("rst_err_count", err_count, 0);
    endtask

    initial begin
        int base;
        int en0;
        bit ok;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_reset_values();
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (2) begin @(posedge clk); #1; end

        // Single write, push-to-issue latency
        push(7'h50, 1'b0, 8'hA5);
        @(negedge clk);
        chk("wr_no_enable_yet", m_enable, 0);
        chk("wr_busy", busy, 1);
        @(negedge clk);
        chk("wr_enable", m_enable, 1);
        chk("wr_m_addr", m_addr, 7'h50);
        chk("wr_m_rw", m_rw, 0);
        chk("wr_m_data_in", m_data_in, 8'hA5);
        wait_rsp(100);
        chk("wr_rsp", {rsp_data, rsp_rw, rsp_err}, {8'h00, 1'b0, 1'b0});
        chk("wr_err_count", err_count, 0);
        drain(100);

        // Single read with known slave data
        use_fixed = 1; fixed_data = 8'h96;
        push(7'h3C, 1'b1, 8'hFF);
        wait_rsp(100);
        chk("rd_rsp", {rsp_data, rsp_rw, rsp_err}, {8'h96, 1'b1, 1'b0});
        drain(100);
        use_fixed = 0;

        // Burst of CMD_DEPTH+1 writes with responses held back
        hold_off = 1;
        repeat (2) begin @(posedge clk); #1; end
        base = pops;
        for (int i = 0; i < 4; i++) push(7'(8'h10 + i), 1'b0, 8'(i));
        @(negedge clk);
        chk("burst_cmd_full", cmd_ready, 0);
        chk("burst_no_issue", m_enable, 0);
        @(posedge clk);
        #1;
        hold_off = 0;
        push(7'h14, 1'b0, 8'h04);
        repeat (150) @(negedge clk);
        chk("burst_rsp_valid", rsp_valid, 1);
        chk("burst_stalled", m_enable, 0);
        chk("burst_busy", busy, 1);
        chk("burst_cmd_ready", cmd_ready, 1);
        drain(300);
        chk("burst_pops", pops - base, 5);

        // Dead master: issue phase times out
        dead_mode = 1;
        en0 = en_cycles;
        push(7'h22, 1'b1, 8'h00);
        wait_rsp(200);
        chk("to_rsp", {rsp_data, rsp_rw, rsp_err}, {8'h00, 1'b1, 1'b1});
        chk("to_err_count", err_count, 1);
        chk("to_enable_cycles", en_cycles - en0, TO);
        chk("to_enable_low", m_enable, 0);
        chk("to_idle", busy, 0);
        dead_mode = 0;
        drain(100);

        // Reset while the master is busy
        stretch = 30;
        push(7'h33, 1'b1, 8'h00);
        ok = 0;
        for (int i = 0; i < 100 && !ok; i++) begin @(negedge clk); if (m_enable) ok = 1; end
        chk("rb_enable_seen", ok, 1);
        ok = 0;
        for (int i = 0; i < 100 && !ok; i++) begin @(negedge clk); if (!m_enable) ok = 1; end
        chk("rb_enable_drop", ok, 1);
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        #1 chk_reset_values();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        stretch = 0;
        repeat (10) @(negedge clk);
        chk("rb_no_rsp", rsp_valid, 0);
        @(posedge clk);
        #1;
        push(7'h11, 1'b0, 8'h5A);
        wait_rsp(100);
        chk("rb_after_rsp", {rsp_data, rsp_rw, rsp_err}, {8'h00, 1'b0, 1'b0});
        chk("rb_err_cleared", err_count, 0);
        drain(100);

        // Randomized traffic with occasional dead or stuck master
        rand_faults = 1;
        rsp_mode = 2;
        for (int n = 0; n < 150; n++) begin
            int g;
            g = $urandom_range(0, 3);
            repeat (g) begin @(posedge clk); #1; end
            push(7'($urandom), 1'($urandom), 8'($urandom));
        end
        rand_faults = 0;
        drain(3000);

        // err_count saturation
        dead_mode = 1;
        rsp_mode = 1;
        for (int n = 0; n < 257; n++) push(7'($urandom), 1'b1, 8'($urandom));
        drain(1000);
        chk("err_saturate", err_count, 255);
        dead_mode = 0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
